// File: rtl/alu_sub_arbiter.sv
// Round-robin arbiter sharing one 32-bit add/sub unit among NREQ requesters,
// with a single registered result slot. Define ALU_SUB_ARB_OVF_EN to add rsp_ovf_o.
module alu_sub_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NREQ-1:0]      req_valid_i,
  output logic [NREQ-1:0]      req_ready_o,
  input  logic [NREQ-1:0]      req_op_i,
  input  logic [32*NREQ-1:0]   req_a_i,
  input  logic [32*NREQ-1:0]   req_b_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [IDW-1:0]       rsp_id_o,
  output logic [31:0]          rsp_c_o
`ifdef ALU_SUB_ARB_OVF_EN
  ,
  output logic                 rsp_ovf_o
`endif
);

  typedef enum logic {EMPTY, FULL} slot_state_t;

  slot_state_t    state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

  logic           hi_vld, lo_vld, grant_vld;
  logic [IDW-1:0] hi_idx, lo_idx, grant_idx;
  logic           can_accept, transfer;
  logic           sel_op;
  logic [31:0]    sel_a, sel_b, sum;

  // Round-robin: first valid at or above rr_ptr, otherwise the lowest valid index.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    hi_vld = 1'b0;
    hi_idx = '0;
    lo_vld = 1'b0;
    lo_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!hi_vld && req_valid_i[i] && (IDW'(i) >= rr_ptr_q)) begin
        hi_vld = 1'b1;
        hi_idx = IDW'(i);
      end
      if (!lo_vld && req_valid_i[i]) begin
        lo_vld = 1'b1;
        lo_idx = IDW'(i);
      end
    end
    grant_vld = hi_vld | lo_vld;
    grant_idx = hi_vld ? hi_idx : lo_idx;
  end

  assign can_accept = (state_q == EMPTY) || rsp_ready_i;
  assign transfer   = !rst_i && grant_vld && can_accept;

  always_comb begin
    req_ready_o = '0;
    sel_op      = 1'b0;
    sel_a       = '0;
    sel_b       = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready_o[i] = transfer && (grant_idx == IDW'(i));
      if (grant_idx == IDW'(i)) begin
        sel_op = req_op_i[i];
        sel_a  = req_a_i[32*i +: 32];
        sel_b  = req_b_i[32*i +: 32];
      end
    end
  end

  // Subtraction as a + ~b + 1 through the same adder.
  assign sum = sel_a + (sel_op ? ~sel_b : sel_b) + 32'(sel_op);

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    if (transfer) begin
      state_d  = FULL;
      rr_ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
    end else if (rsp_ready_i) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: registers update with non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      state_q  <= EMPTY;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_id_o <= '0;
      rsp_c_o  <= '0;
    end else if (transfer) begin
      rsp_id_o <= grant_idx;
      rsp_c_o  <= sum;
    end
  end

  assign rsp_valid_o = (state_q == FULL);

`ifdef ALU_SUB_ARB_OVF_EN
  // Overflow when the result sign differs from a while the effective operand signs agree.
  logic ovf;
  assign ovf = (sel_a[31] ^ sum[31]) & ~(sel_a[31] ^ sel_b[31] ^ sel_op);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_ovf_o <= 1'b0;
    end else if (transfer) begin
      rsp_ovf_o <= ovf;
    end
  end
`endif

endmodule

// File: tb/tb_alu_sub_arbiter.sv
// Self-checking bench for alu_sub_arbiter: directed vectors, corner sequences and
// random traffic compared against a cycle-level behavioural model.
module tb_alu_sub_arbiter;
  localparam int NREQ = 2;
  localparam int IDW  = 2;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic [NREQ-1:0]     req_valid_i, req_ready_o, req_op_i;
  logic [32*NREQ-1:0]  req_a_i, req_b_i;
  logic                rsp_valid_o, rsp_ready_i;
  logic [IDW-1:0]      rsp_id_o;
  logic [31:0]         rsp_c_o;
`ifdef ALU_SUB_ARB_OVF_EN
  logic                rsp_ovf_o;
`endif

  always #5 clk_i = ~clk_i;

  alu_sub_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_op_i    (req_op_i),
    .req_a_i     (req_a_i),
    .req_b_i     (req_b_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_id_o    (rsp_id_o),
    .rsp_c_o     (rsp_c_o)
`ifdef ALU_SUB_ARB_OVF_EN
    ,
    .rsp_ovf_o   (rsp_ovf_o)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Behavioural model state: the result slot and the next requester to favour.
  bit          m_valid;
  int          m_id;
  logic [31:0] m_c;
  bit          m_ovf;
  int          m_rr;
  bit          last_acc;
  int          last_g;

  typedef struct {
    bit          op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    bit          ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick_grant();
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_rr + k) % NREQ;
      if (req_valid_i[i]) return i;
    end
    return -1;
  endfunction

  // Inputs are driven before the call; ready is checked at negedge, outputs after the edge.
  task automatic cycle();
    int          g;
    bit          acc;
    logic [31:0] a, b;
    longint      s;
    @(negedge clk_i);
    g   = pick_grant();
    acc = !rst_i && (g >= 0) && (!m_valid || rsp_ready_i);
    for (int i = 0; i < NREQ; i++)
      check($sformatf("req_ready[%0d]", i), 64'(req_ready_o[i]), 64'(acc && (g == i)));
    if (rst_i) begin
      m_valid = 0; m_id = 0; m_c = 0; m_ovf = 0; m_rr = 0;
    end else if (acc) begin
      a = req_a_i[32*g +: 32];
      b = req_b_i[32*g +: 32];
      m_c = req_op_i[g] ? a - b : a + b;
      s = req_op_i[g] ? longint'($signed(a)) - longint'($signed(b))
                      : longint'($signed(a)) + longint'($signed(b));
      m_ovf   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      m_id    = g;
      m_valid = 1;
      m_rr    = (g + 1) % NREQ;
    end else if (rsp_ready_i) begin
      m_valid = 0;
    end
    last_acc = acc;
    last_g   = g;
    @(posedge clk_i);
    #1;
    check("rsp_valid", 64'(rsp_valid_o), 64'(m_valid));
    check("rsp_id", 64'(rsp_id_o), 64'(m_id));
    check("rsp_c", 64'(rsp_c_o), 64'(m_c));
`ifdef ALU_SUB_ARB_OVF_EN
    check("rsp_ovf", 64'(rsp_ovf_o), 64'(m_ovf));
`endif
  endtask

  task automatic set_req(input int i, input bit op, input logic [31:0] a, input logic [31:0] b);
    req_valid_i[i]       = 1'b1;
    req_op_i[i]          = op;
    req_a_i[32*i +: 32]  = a;
    req_b_i[32*i +: 32]  = b;
  endtask

  initial begin
    vecs[0] = '{op: 1, a: 32'h0000_0005, b: 32'h0000_0007, c: 32'hFFFF_FFFE, ovf: 0};
    vecs[1] = '{op: 0, a: 32'hFFFF_FFFF, b: 32'h0000_0001, c: 32'h0000_0000, ovf: 0};
    vecs[2] = '{op: 1, a: 32'h0000_0000, b: 32'h8000_0000, c: 32'h8000_0000, ovf: 1};
    vecs[3] = '{op: 0, a: 32'h7FFF_FFFF, b: 32'h0000_0001, c: 32'h8000_0000, ovf: 1};
    vecs[4] = '{op: 1, a: 32'hDEAD_BEEF, b: 32'h0000_0000, c: 32'hDEAD_BEEF, ovf: 0};
    vecs[5] = '{op: 1, a: 32'h1234_5678, b: 32'h8000_0000, c: 32'h9234_5678, ovf: 1};
    vecs[6] = '{op: 1, a: 32'h8000_0000, b: 32'h0000_0001, c: 32'h7FFF_FFFF, ovf: 1};
    vecs[7] = '{op: 0, a: 32'h8000_0000, b: 32'h8000_0000, c: 32'h0000_0000, ovf: 1};

    rst_i = 1; rsp_ready_i = 1;
    req_valid_i = '0; req_op_i = '0; req_a_i = '0; req_b_i = '0;
    m_valid = 0; m_id = 0; m_c = 0; m_ovf = 0; m_rr = 0;
    @(posedge clk_i); #1;
    cycle();
    cycle();
    rst_i = 0;

    // Directed vectors, one requester at a time.
    for (int v = 0; v < 8; v++) begin
      set_req(v % NREQ, vecs[v].op, vecs[v].a, vecs[v].b);
      cycle();
      check($sformatf("vec%0d_c", v), 64'(rsp_c_o), 64'(vecs[v].c));
      check($sformatf("vec%0d_id", v), 64'(rsp_id_o), 64'(v % NREQ));
      check($sformatf("vec%0d_valid", v), 64'(rsp_valid_o), 64'(1));
`ifdef ALU_SUB_ARB_OVF_EN
      check($sformatf("vec%0d_ovf", v), 64'(rsp_ovf_o), 64'(vecs[v].ovf));
`endif
      req_valid_i = '0;
    end
    cycle();

    // Round-robin after reset: both valid, ids alternate 0,1,0,1.
    rst_i = 1; cycle(); rst_i = 0;
    set_req(0, 0, 32'd10, 32'd1);
    set_req(1, 0, 32'd20, 32'd2);
    for (int k = 0; k < 4; k++) begin
      cycle();
      check($sformatf("rr_id%0d", k), 64'(rsp_id_o), 64'(k % 2));
    end
    req_valid_i = '0;
    cycle();

    // Backpressure: slot held for 3 cycles, pending request taken as soon as ready returns.
    set_req(0, 0, 32'd100, 32'd1);
    cycle();
    req_valid_i = '0;
    rsp_ready_i = 0;
    set_req(1, 0, 32'd7, 32'd8);
    for (int k = 0; k < 3; k++) begin
      cycle();
      check($sformatf("bp_ready%0d", k), 64'(req_ready_o), 64'(0));
      check($sformatf("bp_hold%0d", k), 64'(rsp_c_o), 64'(101));
    end
    rsp_ready_i = 1;
    cycle();
    check("bp_resume_c", 64'(rsp_c_o), 64'(15));
    check("bp_resume_valid", 64'(rsp_valid_o), 64'(1));
    check("bp_resume_id", 64'(rsp_id_o), 64'(1));

    // Reset while FULL and stalled, with a request present during reset.
    rsp_ready_i = 0;
    cycle();
    req_valid_i = '0;
    set_req(1, 1, 32'd50, 32'd5);
    rst_i = 1;
    cycle();
    check("rst_valid", 64'(rsp_valid_o), 64'(0));
    check("rst_c", 64'(rsp_c_o), 64'(0));
    rst_i = 0;
    rsp_ready_i = 1;
    set_req(0, 0, 32'd3, 32'd4);
    cycle();
    check("post_rst_id", 64'(rsp_id_o), 64'(0));
    check("post_rst_c", 64'(rsp_c_o), 64'(7));
    req_valid_i[0] = 1'b0;

    // Random traffic honouring the hold-until-accepted rule.
    for (int n = 0; n < 400; n++) begin
      if (last_acc && last_g >= 0) req_valid_i[last_g] = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid_i[i] && $urandom_range(0, 2) != 0) begin
          logic [31:0] a, b;
          a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
          b = ($urandom_range(0, 7) == 0) ? 32'h0000_0000 : $urandom;
          set_req(i, 1'($urandom_range(0, 1)), a, b);
        end
      end
      rsp_ready_i = ($urandom_range(0, 3) != 0);
      rst_i       = ($urandom_range(0, 99) == 0);
      cycle();
    end
    rst_i = 0;
    req_valid_i = '0;
    rsp_ready_i = 1;
    cycle();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
